game_mem_arb: RTL and testbench
===============================

Name: game_mem_arb

Overview:
- Two-requester round-robin arbiter and sequencer for the single-port game memory (16 x 8, per-entry valid bits, combinational read, synchronous active-low clear).
- Lets the draw engine (requester 0) and the card checker (requester 1) share the memory with a valid/ready request and a registered read response.
- Also owns the memory's clear input and sequences a full-board clear on power-up and on request.

Parameters:
- ADDR_WIDTH, 4, memory address width (ENTRIES = 2**ADDR_WIDTH).
- DATA_WIDTH, 8, memory data width.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-requester request valid; bit i is requester i.
- req_ready  out  2  per-requester grant; request accepted when valid & ready.
- req_we  in  2  per-requester write enable (1 = write, 0 = read).
- req_addr  in  2*ADDR_WIDTH  addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  2*DATA_WIDTH  write data, sliced the same way.
- rsp_valid  out  2  one-cycle read-response strobe per requester.
- rsp_rdata  out  DATA_WIDTH  read data, valid while any rsp_valid bit is high.
- clear_req  in  1  request a full memory clear (level or pulse).
- clear_busy  out  1  high while a clear is in progress.
- mem_addr  out  ADDR_WIDTH  to memory addr.
- mem_data_in  out  DATA_WIDTH  to memory data_in.
- mem_write_en  out  1  to memory write_en.
- mem_data_out  in  DATA_WIDTH  from memory data_out (combinational read).
- mem_rstn  out  1  to memory rstn (memory samples it synchronously); driven from a register.

Behaviour:
- FSM has two states, CLR and RUN; the reset state is CLR.
- Reset values: mem_rstn=0, rsp_valid=0, rsp_rdata=0, round-robin pointer last=1 (requester 0 wins the first tie).
- CLR state:
  - mem_rstn=0; clear_busy=1; req_ready=0; mem_write_en=0.
  - The next edge sets mem_rstn=1 and moves to RUN. The memory clears its valid bits at that same edge.
  - After rstn deasserts there is exactly one CLR cycle.
- RUN with clear_req=1:
  - No grants that cycle (req_ready=0).
  - The next edge sets mem_rstn=0 and moves to CLR.
  - Clear therefore blocks access for 2 cycles. clear_req seen in CLR is ignored; a held clear_req re-triggers a clear once the block is back in RUN.
- RUN with clear_req=0:
  - Exactly one requester is granted per cycle, and req_ready is one-hot or zero.
  - If only one requester is valid, it is granted.
  - If both are valid, the one not equal to last is granted.
  - last updates to the granted index at the edge. It does not change on idle cycles.
- Memory drive (combinational, granted requester only):
  - mem_addr and mem_data_in come from the granted slice.
  - mem_write_en = granted req_we.
  - With no grant: mem_write_en=0, mem_addr=0, mem_data_in=0.
- Read response:
  - On an accepted read, rsp_rdata <= mem_data_out at the edge, and rsp_valid[granted] is high for the following cycle only.
  - Read latency is 1 cycle. Back-to-back reads give back-to-back responses.
  - rsp_rdata holds its last value when rsp_valid=0.
- Writes produce no response. The write takes effect at the edge that accepts it, so a read of the same address in the next cycle returns the new data.
- A read of a never-written or cleared address returns 0 (memory valid-bit behaviour).
- Requesters must hold valid/we/addr/wdata until accepted. Arbitration does not depend on req_we.
- rstn asserted mid-operation: everything returns immediately to reset values, and any pending response is dropped.

Decomposition:
- Shared package game_pkg holds:
  - GAME_ADDR_WIDTH=4, GAME_DATA_WIDTH=8, GAME_ENTRIES=16.
  - FSM encoding ST_CLR=1'b0, ST_RUN=1'b1.
  - Requester index constants REQ_DRAW=0, REQ_CHECK=1.
- One sub-module, rr_arb2: 2-way round-robin grant with the last pointer, an enable input (low during clear), and a one-hot grant output.

Test Plan:
- Reset then idle: after rstn rises, clear_busy=1 and mem_rstn=0 for 1 cycle, then 1/0; rsp_valid stays 00; any read of addr 5 returns 0x00.
- Req0 writes 0x2A to addr 3 (granted same cycle, mem_write_en=1), then req1 reads addr 3 -> rsp_valid=10 next cycle, rsp_rdata=0x2A.
- Both valid for 4 consecutive cycles (reads of addrs 1 and 2) -> grants alternate 01,10,01,10; responses follow one cycle later on the matching rsp_valid bit.
- Single requester: req1 valid alone for 3 cycles -> req_ready=10 each cycle; then both valid -> req0 granted first.
- Clear: write 0x11 to addr 7, then pulse clear_req with both requesters valid -> 0 grants for 2 cycles, clear_busy high in the second; read of addr 7 afterwards returns 0x00.
- Async reset mid-read: assert rstn low between an accepted read and its response -> rsp_valid never asserts, and all outputs are at reset values immediately.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared widths, FSM encoding and requester indices for the game memory arbiter.
package game_pkg;
    localparam int GAME_ADDR_WIDTH = 4;
    localparam int GAME_DATA_WIDTH = 8;
    localparam int GAME_ENTRIES    = 16;
    localparam int REQ_DRAW        = 0;
    localparam int REQ_CHECK       = 1;
    typedef enum logic {ST_CLR = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; a tie goes to the requester that did not win last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_en,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);
    logic r_last;
    assign o_grant[0] = i_en & i_valid[0] & (~i_valid[1] | r_last);
    assign o_grant[1] = i_en & i_valid[1] & (~i_valid[0] | ~r_last);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_last <= 1'b1;
        else if (|o_grant) r_last <= o_grant[1];
    end
endmodule

// File: rtl/game_mem_arb.sv
// game_mem_arb: shares the single-port game memory between draw engine and card checker
// and sequences full-board clears through the memory's synchronous clear input.
module game_mem_arb
    import game_pkg::*;
#(
    parameter int ADDR_WIDTH = GAME_ADDR_WIDTH,
    parameter int DATA_WIDTH = GAME_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    input  logic                    clear_req,
    output logic                    clear_busy,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_data_in,
    output logic                    mem_write_en,
    input  logic [DATA_WIDTH-1:0]   mem_data_out,
    output logic                    mem_rstn
);
    state_t                r_state;
    logic                  r_mem_rstn;
    logic [1:0]            r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [1:0]            w_gnt;
    logic                  w_rd;
    rr_arb2 u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .i_en    (r_state == ST_RUN && !clear_req),
        .i_valid (req_valid),
        .o_grant (w_gnt)
    );
    assign req_ready    = w_gnt;
    assign clear_busy   = (r_state == ST_CLR);
    assign mem_rstn     = r_mem_rstn;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign mem_addr     = w_gnt[REQ_CHECK] ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                        : w_gnt[REQ_DRAW]  ? req_addr[ADDR_WIDTH-1:0] : '0;
    assign mem_data_in  = w_gnt[REQ_CHECK] ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                        : w_gnt[REQ_DRAW]  ? req_wdata[DATA_WIDTH-1:0] : '0;
    assign mem_write_en = |(w_gnt & req_we);
    assign w_rd         = |w_gnt & ~mem_write_en;
    // mem_rstn mirrors the next state so the memory clears on the CLR->RUN edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_CLR;
            r_mem_rstn  <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_rd ? w_gnt : 2'b00;
            if (w_rd) r_rsp_rdata <= mem_data_out;
            if (r_state == ST_CLR) begin
                r_state    <= ST_RUN;
                r_mem_rstn <= 1'b1;
            end else if (clear_req) begin
                r_state    <= ST_CLR;
                r_mem_rstn <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_game_mem_arb.sv
// tb_game_mem_arb: directed and randomized checks of game_mem_arb against a
// cycle-level reference model, with a behavioural 16x8 valid-bit memory attached.
module tb_game_mem_arb;
    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [7:0]  rsp_rdata, mem_data_in, mem_data_out;
    logic [3:0]  mem_addr;
    logic        clear_req, clear_busy, mem_write_en, mem_rstn;
    int checks = 0, failures = 0;

    game_mem_arb dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .clear_req(clear_req),
        .clear_busy(clear_busy), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_write_en(mem_write_en), .mem_data_out(mem_data_out), .mem_rstn(mem_rstn)
    );

    always #5 clk = ~clk;

    // behavioural game memory: valid bits cleared synchronously by mem_rstn
    logic [15:0] bm_val;
    logic [7:0]  bm_d [16];
    always @(posedge clk) begin
        if (!mem_rstn) bm_val <= '0;
        else if (mem_write_en) begin
            bm_val[mem_addr] <= 1'b1;
            bm_d[mem_addr]   <= mem_data_in;
        end
    end
    assign mem_data_out = bm_val[mem_addr] ? bm_d[mem_addr] : 8'h00;

    // reference model state
    bit         m_clr;
    int         m_last;
    logic [1:0] m_rsp;
    logic [7:0] m_rdata;
    logic [7:0] m_mem [16];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clr = 1; m_last = 1; m_rsp = 2'b00; m_rdata = 8'h00;
    endtask

    // one clock cycle; entered and left at posedge+1
    task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [3:0] a0, input logic [3:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1, input logic clr, output logic [1:0] g);
        int w;
        logic [3:0] ea;
        logic [7:0] ed;
        req_valid = v; req_we = we; req_addr = {a1, a0}; req_wdata = {d1, d0}; clear_req = clr;
        #3;
        w = -1;
        if (!m_clr && !clr) begin
            if (v == 2'b11) w = 1 - m_last;
            else if (v == 2'b01) w = 0;
            else if (v == 2'b10) w = 1;
        end
        g  = (w < 0) ? 2'b00 : 2'(1 << w);
        ea = (w == 0) ? a0 : (w == 1) ? a1 : 4'h0;
        ed = (w == 0) ? d0 : (w == 1) ? d1 : 8'h00;
        chk("clear_busy", 16'(clear_busy), 16'(m_clr));
        chk("mem_rstn", 16'(mem_rstn), 16'(!m_clr));
        chk("req_ready", 16'(req_ready), 16'(g));
        chk("mem_write_en", 16'(mem_write_en), 16'((w >= 0) && we[w[0]]));
        chk("mem_addr", 16'(mem_addr), 16'(ea));
        chk("mem_data_in", 16'(mem_data_in), 16'(ed));
        chk("rsp_valid", 16'(rsp_valid), 16'(m_rsp));
        chk("rsp_rdata", 16'(rsp_rdata), 16'(m_rdata));
        @(posedge clk);
        #1;
        if (m_clr) begin
            m_clr = 0;
            foreach (m_mem[i]) m_mem[i] = 8'h00;
        end else if (clr) m_clr = 1;
        m_rsp = 2'b00;
        if (w >= 0) begin
            m_last = w;
            if (we[w[0]]) m_mem[ea] = ed;
            else begin
                m_rsp   = g;
                m_rdata = m_mem[ea];
            end
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; clear_req = 0;
        #2;
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("rst_rsp_rdata", 16'(rsp_rdata), 16'h0);
        chk("rst_mem_rstn", 16'(mem_rstn), 16'h0);
        chk("rst_clear_busy", 16'(clear_busy), 16'h1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    logic [1:0] g;
    logic [1:0] hv, hw;
    logic [3:0] ha [2];
    logic [7:0] hd [2];
    logic       clr;

    initial begin
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        #6;
        do_reset();
        // reset then idle, read of addr 5 returns 0
        step(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, g);
        step(2'b01, 2'b00, 4'h5, 4'h0, 8'h00, 8'h00, 1'b0, g);
        chk("rd5_valid", 16'(rsp_valid), 16'h1);
        chk("rd5_data", 16'(rsp_rdata), 16'h00);
        // write 0x2A to addr 3 by req0, read back by req1
        step(2'b01, 2'b01, 4'h3, 4'h0, 8'h2A, 8'h00, 1'b0, g);
        step(2'b10, 2'b00, 4'h0, 4'h3, 8'h00, 8'h00, 1'b0, g);
        chk("rd3_valid", 16'(rsp_valid), 16'h2);
        chk("rd3_data", 16'(rsp_rdata), 16'h2A);
        // both valid: alternation
        for (int i = 0; i < 4; i++) step(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 1'b0, g);
        // req1 alone, then both valid
        for (int i = 0; i < 3; i++) step(2'b10, 2'b00, 4'h0, 4'h3, 8'h00, 8'h00, 1'b0, g);
        step(2'b11, 2'b00, 4'h3, 4'h3, 8'h00, 8'h00, 1'b0, g);
        chk("tie_after_req1", 16'(g), 16'h1);
        // clear sequence
        step(2'b01, 2'b01, 4'h7, 4'h0, 8'h11, 8'h00, 1'b0, g);
        step(2'b11, 2'b00, 4'h7, 4'h7, 8'h00, 8'h00, 1'b1, g);
        step(2'b11, 2'b00, 4'h7, 4'h7, 8'h00, 8'h00, 1'b0, g);
        step(2'b01, 2'b00, 4'h7, 4'h0, 8'h00, 8'h00, 1'b0, g);
        step(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, g);
        chk("clr_rd7", 16'(rsp_rdata), 16'h00);
        // held clear_req re-triggers
        for (int i = 0; i < 4; i++) step(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00, 1'b1, g);
        // async reset during a read that would be accepted
        step(2'b01, 2'b01, 4'h4, 4'h0, 8'h5C, 8'h00, 1'b0, g);
        req_valid = 2'b10; req_we = 2'b00; req_addr = 8'h40; clear_req = 1'b0;
        #1;
        rstn = 1'b0;
        #1;
        chk("ar_req_ready", 16'(req_ready), 16'h0);
        chk("ar_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("ar_clear_busy", 16'(clear_busy), 16'h1);
        chk("ar_mem_rstn", 16'(mem_rstn), 16'h0);
        chk("ar_mem_we", 16'(mem_write_en), 16'h0);
        @(posedge clk);
        #1;
        chk("ar_rsp_after", 16'(rsp_valid), 16'h0);
        do_reset();
        // randomized traffic: requesters hold requests until accepted
        hv = 2'b00;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!hv[i] && $urandom_range(0, 2) != 0) begin
                    hv[i] = 1'b1;
                    hw[i] = 1'($urandom_range(0, 1));
                    ha[i] = 4'($urandom_range(0, 7));
                    hd[i] = 8'($urandom);
                end
            end
            clr = ($urandom_range(0, 24) == 0);
            step(hv, hw, ha[0], ha[1], hd[0], hd[1], clr, g);
            hv = hv & ~g;
        end
        step(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, g);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
